mips32_mem_arbiter: RTL
=======================

Name: mips32_mem_arbiter

Overview:
- Arbitrates the single-ported 1024 x 32 unified program/data memory between three requesters:
  - the instruction-fetch stage (IF),
  - the MEM stage (LW/SW data port, D),
  - a program loader (LD) that fills or dumps memory while the core is halted.
- Sits between the pipeline stages and the memory array.
- Provides fixed priority with fetch anti-starvation, a registered read-return path and a fetch-stall statistics counter.

Parameters:
- AW, 10: memory word-address width (1024 words).
- DW, 32: data width.
- STARVE_MAX, 4: consecutive denied fetch cycles after which fetch is forced to win over data.
- CW, 16: width of the saturating fetch-stall counter.

Ports:
- clk1  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- halted  input  1  core halted; only loader is served when 1.
- if_req  input  1  fetch read request.
- if_addr  input  AW  fetch word address.
- if_gnt  output  1  fetch accepted this cycle (combinational).
- if_rvalid  output  1  fetch read data valid on rdata.
- d_req  input  1  data request.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  AW  data word address.
- d_wdata  input  DW  store data.
- d_gnt  output  1  data accepted this cycle (combinational).
- d_rvalid  output  1  load data valid on rdata.
- ld_req  input  1  loader request.
- ld_we  input  1  loader write enable.
- ld_addr  input  AW  loader address.
- ld_wdata  input  DW  loader write data.
- ld_gnt  output  1  loader accepted (combinational).
- ld_rvalid  output  1  loader read data valid on rdata.
- rdata  output  DW  shared read-return data.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write strobe.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, registered by memory: valid the cycle after mem_en with mem_we=0.
- stall_cnt  output  CW  count of cycles with if_req=1 and if_gnt=0.

Behaviour:
- At most one grant per cycle. The granted port's addr, we and wdata drive mem_* combinationally with mem_en=1. No grant → mem_en=0, mem_we=0.
- halted=1:
  - ld_gnt = ld_req.
  - if_gnt = d_gnt = 0.
  - starve_cnt is held.
- halted=0:
  - ld_gnt = 0.
  - If if_req && starve_cnt == STARVE_MAX, fetch is granted.
  - Else if d_req, data is granted.
  - Else if if_req, fetch is granted.
- Fetch is always a read; mem_we=0 for fetch grants.
- starve_cnt (internal, 0..STARVE_MAX):
  - Cleared on reset, on a fetch grant, or when if_req=0.
  - Incremented, saturating at STARVE_MAX, when if_req=1 and data is granted.
- Read return:
  - A read grant in cycle N sets exactly one of if_rvalid/d_rvalid/ld_rvalid in cycle N+1, with rdata = mem_rdata in that cycle.
  - Owner is held in a 2-bit register (NONE/IF/D/LD).
  - Write grants produce no rvalid; the gnt pulse is the write acknowledgement.
  - Back-to-back reads return back-to-back, one per cycle.
  - rdata is 0 when no rvalid is asserted.
- A request not granted must be held by the requester. The arbiter keeps no request queue.
- stall_cnt:
  - Increments when if_req=1 and if_gnt=0, including while halted.
  - Saturates at 2^CW-1 with no wrap.
  - Cleared only by reset.
- halted toggling with a read in flight: the pending rvalid is still delivered to the original owner the next cycle.
- Reset:
  - All gnt, rvalid and mem_* outputs are 0.
  - rdata=0, stall_cnt=0, starve_cnt=0, owner=NONE.
  - A pending read return is discarded. No rvalid is issued in the cycle after reset deasserts.

Test Plan:
- halted=0, if_req alone at addr 5 → if_gnt=1 and mem_addr=5 the same cycle; next cycle if_rvalid=1 and rdata=MEM[5].
- halted=0, d_req (load, addr 20) and if_req together for 6 cycles → d_gnt cycles 1-4, if_gnt cycle 5, d_gnt cycle 6; stall_cnt=5 after cycle 6.
- d_req store addr 7, wdata 32'hDEADBEEF → mem_we=1, mem_wdata=32'hDEADBEEF, d_gnt=1, no d_rvalid next cycle.
- halted=1 with ld_req, d_req and if_req all asserted → only ld_gnt=1. A loader read of addr 3 returns ld_rvalid and rdata=MEM[3] the next cycle; stall_cnt increments each cycle.
- Reset asserted the cycle after a granted read → no rvalid the following cycle, all outputs 0, stall_cnt=0.
- Hold if_req with d_req low for 2^CW+3 cycles under halted=1 → stall_cnt saturates at 16'hFFFF with no wrap.

Source files
------------

// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the three memory requesters (fetch, data, loader), the
// arbiter and the single-ported program/data memory.
//
// Signal groups:
//   halted                          core halted; only the loader is served
//   if_*  req/addr -> gnt/rvalid    instruction fetch (read only)
//   d_*   req/we/addr/wdata -> gnt/rvalid   MEM-stage load/store port
//   ld_*  req/we/addr/wdata -> gnt/rvalid   program loader port
//   rdata                           shared read-return data
//   mem_* en/we/addr/wdata -> rdata memory array port
//   stall_cnt                       saturating count of denied fetch cycles
//
// Handshake: a requester raises *_req with its address/data and must hold all
// of them unchanged until the cycle in which *_gnt is 1; that cycle is the
// transfer. A granted read returns exactly one *_rvalid pulse, with data on
// rdata, in the following cycle. A granted write has no rvalid; the gnt pulse
// is its acknowledgement.
//
// Modports: slave = arbiter side, master = requesters/memory side.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int CW = 16
);
  logic          halted;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;

  logic [DW-1:0] rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [CW-1:0] stall_cnt;

  modport slave (
    input  halted,
    input  if_req, if_addr,
    output if_gnt, if_rvalid,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall_cnt
  );

  modport master (
    output halted,
    output if_req, if_addr,
    input  if_gnt, if_rvalid,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall_cnt
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Arbiter for the single-ported 1024 x 32 unified program/data memory.
// Fixed priority (loader while halted; otherwise data over fetch) with a
// fetch anti-starvation counter, a registered read-return path and a
// saturating fetch-stall statistics counter.
//
// Ports:
//   clk1       single clock, all state updates on posedge
//   reset      synchronous, active-high
//   bus        mips32_mem_arbiter_if.slave (requesters + memory port)
//   owner_dbg  current read-return owner (0 none, 1 fetch, 2 data, 3 loader)
//
// The interface instance must be parameterised with the same AW/DW/CW.
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int CW         = 16
) (
  input  logic                       clk1,
  input  logic                       reset,
  mips32_mem_arbiter_if.slave        bus,
  output logic [1:0]                 owner_dbg
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  // Who receives the read data arriving from memory this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2,
    OWN_LD   = 2'd3
  } owner_t;

  owner_t        owner_q, owner_d;
  logic [SW-1:0] starve_q;
  logic [CW-1:0] stall_q;

  logic          if_gnt_c, d_gnt_c, ld_gnt_c;
  logic          mem_en_c, mem_we_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wdata_c;

  // Grant selection. Reset forces all grants low so nothing reaches memory.
  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    ld_gnt_c = 1'b0;
    if (!reset) begin
      if (bus.halted) begin
        ld_gnt_c = bus.ld_req;
      end else if (bus.if_req && (starve_q == STARVE_LIM)) begin
        // Fetch has lost to data too many times in a row.
        if_gnt_c = 1'b1;
      end else if (bus.d_req) begin
        d_gnt_c = 1'b1;
      end else if (bus.if_req) begin
        if_gnt_c = 1'b1;
      end
    end
  end

  // Memory port mux; fetch is always a read.
  always_comb begin
    mem_en_c    = if_gnt_c | d_gnt_c | ld_gnt_c;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (ld_gnt_c) begin
      mem_we_c    = bus.ld_we;
      mem_addr_c  = bus.ld_addr;
      mem_wdata_c = bus.ld_wdata;
    end else if (d_gnt_c) begin
      mem_we_c    = bus.d_we;
      mem_addr_c  = bus.d_addr;
      mem_wdata_c = bus.d_wdata;
    end else if (if_gnt_c) begin
      mem_addr_c  = bus.if_addr;
    end
  end

  // Read-return owner: next value is the port whose read is granted now.
  always_comb begin
    owner_d = OWN_NONE;
    if (ld_gnt_c && !bus.ld_we) begin
      owner_d = OWN_LD;
    end else if (d_gnt_c && !bus.d_we) begin
      owner_d = OWN_D;
    end else if (if_gnt_c) begin
      owner_d = OWN_IF;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      stall_q  <= '0;
    end else begin
      owner_q <= owner_d;

      // While halted neither fetch nor data can win, so the count is frozen.
      if (!bus.halted) begin
        if (if_gnt_c || !bus.if_req) begin
          starve_q <= '0;
        end else if (d_gnt_c && (starve_q != STARVE_LIM)) begin
          starve_q <= starve_q + SW'(1);
        end
      end

      if (bus.if_req && !if_gnt_c && (stall_q != '1)) begin
        stall_q <= stall_q + CW'(1);
      end
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.ld_gnt    = ld_gnt_c;

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  // Gating with reset drops a return that was in flight when reset arrived.
  assign bus.if_rvalid = !reset && (owner_q == OWN_IF);
  assign bus.d_rvalid  = !reset && (owner_q == OWN_D);
  assign bus.ld_rvalid = !reset && (owner_q == OWN_LD);
  assign bus.rdata     = (!reset && (owner_q != OWN_NONE)) ? bus.mem_rdata : '0;

  assign bus.stall_cnt = stall_q;
  assign owner_dbg     = owner_q;

endmodule
